// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory with a fixed
// read latency; one transaction is in flight at a time (IDLE -> ISSUE -> [WAIT] -> RESP).
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gid_q, gid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;
    logic              win_s;

    // Contention goes to whoever was not served last; a lone request always wins.
    assign win_s = (m0_req && m1_req) ? ~last_q : m1_req;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched request, grant bookkeeping, latency counter and read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= 1'b1;
            gid_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= 32'h0000_0000;
            cnt_q      <= 2'd0;
            m0_rdata_q <= 32'h0000_0000;
            m1_rdata_q <= 32'h0000_0000;
        end else begin
            last_q     <= last_d;
            gid_q      <= gid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gid_d      = gid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    gid_d   = win_s;
                    we_d    = win_s ? m1_we    : m0_we;
                    addr_d  = win_s ? m1_addr  : m0_addr;
                    wdata_d = win_s ? m1_wdata : m0_wdata;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (gid_q) begin
                        m1_rdata_d = mem_rdata;
                    end else begin
                        m0_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                last_d  = gid_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register only, so they are glitch-free.
    always_comb begin
        mem_en = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        busy   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_ISSUE: begin
                mem_en = 1'b1;
                busy   = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_RESP: begin
                busy   = 1'b1;
                m0_ack = ~gid_q;
                m1_ack = gid_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign grant_id  = gid_q;
    assign cpu_stall = m0_req & ~m0_ack;

endmodule
